// File: rtl/measure_fsm.sv
// rtl/measure_fsm.sv - ADT7310 one-shot temperature measurement sequencer driving an SPI master FIFO pair
// Optional wait-state watchdog: define MEASURE_FSM_TIMEOUT_EN (adds Error_o).
module measure_fsm #(
  parameter int DataWidth = 8
) (
  input  logic                   Reset_n_i,
  input  logic                   Clk_i,
  input  logic                   Start_i,
  output logic                   Done_o,
`ifdef MEASURE_FSM_TIMEOUT_EN
  output logic                   Error_o,
`endif
  output logic [DataWidth-1:0]   Byte0_o,
  output logic [DataWidth-1:0]   Byte1_o,
  output logic                   SensorCS_n_o,
  output logic [DataWidth-1:0]   SPI_Data_o,
  output logic                   SPI_Write_o,
  output logic                   SPI_ReadNext_o,
  input  logic [DataWidth-1:0]   SPI_Data_i,
  input  logic                   SPI_FIFOFull_i,
  input  logic                   SPI_FIFOEmpty_i,
  input  logic                   SPI_Transmission_i,
  input  logic [2*DataWidth-1:0] ParamCounterPreset_i
);

  typedef enum logic [3:0] {
    stIdle, stCfgCmd, stCfgVal, stCfgWait, stConvWait, stRdCmd, stRdDummy1,
    stRdDummy2, stRdWait, stPop0, stPop1, stPop2, stDone
  } state_e;

  localparam logic [DataWidth-1:0]   CmdWrCfg = DataWidth'(8'h08);
  localparam logic [DataWidth-1:0]   CfgOneShot = DataWidth'(8'h20);
  localparam logic [DataWidth-1:0]   CmdRdTemp = DataWidth'(8'h50);
  localparam logic [DataWidth-1:0]   Dummy = DataWidth'(8'hFF);
  localparam logic [2*DataWidth-1:0] TimerOne = (2*DataWidth)'(1);

  state_e                 state_q, state_d;
  logic [2*DataWidth-1:0] timer_q, timer_d;
  logic                   cs_n_q, cs_n_d;
  logic [DataWidth-1:0]   byte0_q, byte0_d, byte1_q, byte1_d;
  logic                   rd_next;
  logic                   wait_exit;

  // A frame is finished once the master is idle and its response bytes have landed.
  assign wait_exit = !SPI_Transmission_i && !SPI_FIFOEmpty_i;

`ifdef MEASURE_FSM_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       in_wait, timeout;

  assign in_wait = (state_q == stCfgWait) || (state_q == stRdWait);
  assign timeout = in_wait && !wait_exit && (wd_q == 8'hFF);
  // Wait states are never adjacent, so the count is always 0 on entry.
  assign wd_d    = in_wait ? wd_q + 8'd1 : 8'd0;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) wd_q <= 8'd0;
    else            wd_q <= wd_d;
  end
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= stIdle;
      timer_q <= '0;
      cs_n_q  <= 1'b1;
      byte0_q <= '0;
      byte1_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cs_n_q  <= cs_n_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cs_n_d      = cs_n_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    Done_o      = 1'b0;
    SPI_Write_o = 1'b0;
    SPI_Data_o  = '0;
    rd_next     = 1'b0;
`ifdef MEASURE_FSM_TIMEOUT_EN
    Error_o     = 1'b0;
`endif
    case (state_q)
      stIdle: begin
        rd_next = !SPI_FIFOEmpty_i;
        if (Start_i) begin
          cs_n_d  = 1'b0;
          state_d = stCfgCmd;
        end
      end
      stCfgCmd: begin
        SPI_Data_o  = CmdWrCfg;
        SPI_Write_o = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = stCfgVal;
      end
      stCfgVal: begin
        SPI_Data_o  = CfgOneShot;
        SPI_Write_o = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = stCfgWait;
      end
      stCfgWait: begin
        if (wait_exit) begin
          cs_n_d  = 1'b1;
          timer_d = ParamCounterPreset_i;
          state_d = stConvWait;
        end
      end
      stConvWait: begin
        rd_next = !SPI_FIFOEmpty_i;
        if (timer_q == '0) begin
          cs_n_d  = 1'b0;
          state_d = stRdCmd;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      stRdCmd: begin
        SPI_Data_o  = CmdRdTemp;
        SPI_Write_o = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = stRdDummy1;
      end
      stRdDummy1: begin
        SPI_Data_o  = Dummy;
        SPI_Write_o = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = stRdDummy2;
      end
      stRdDummy2: begin
        SPI_Data_o  = Dummy;
        SPI_Write_o = !SPI_FIFOFull_i;
        if (!SPI_FIFOFull_i) state_d = stRdWait;
      end
      stRdWait: begin
        if (wait_exit) begin
          cs_n_d  = 1'b1;
          state_d = stPop0;
        end
      end
      // First RX byte is the response to the read command and carries no data.
      stPop0: begin
        if (!SPI_FIFOEmpty_i) begin
          rd_next = 1'b1;
          state_d = stPop1;
        end
      end
      stPop1: begin
        if (!SPI_FIFOEmpty_i) begin
          rd_next = 1'b1;
          byte1_d = SPI_Data_i;
          state_d = stPop2;
        end
      end
      stPop2: begin
        if (!SPI_FIFOEmpty_i) begin
          rd_next = 1'b1;
          byte0_d = SPI_Data_i;
          state_d = stDone;
        end
      end
      stDone: begin
        Done_o  = 1'b1;
        state_d = stIdle;
      end
      default: state_d = stIdle;
    endcase
`ifdef MEASURE_FSM_TIMEOUT_EN
    if (timeout) begin
      Error_o = 1'b1;
      cs_n_d  = 1'b1;
      state_d = stIdle;
    end
`endif
  end

  // Idle decodes the flush pop, so it must be masked while reset is held.
  assign SPI_ReadNext_o = rd_next & Reset_n_i;
  assign SensorCS_n_o   = cs_n_q;
  assign Byte0_o        = byte0_q;
  assign Byte1_o        = byte1_q;

endmodule

// File: doc/measure_fsm.md
MEASURE_FSM -- requirements
Module: measure_fsm

Interface
REQ-001 Parameter DataWidth, default 8, byte width of SPI data and result bytes.
REQ-002 Reset_n_i  in  1  asynchronous active-low reset.
REQ-003 Clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 Start_i  in  1  request one measurement; sampled in stIdle only.
REQ-005 Done_o  out  1  one-cycle pulse: Byte0_o/Byte1_o hold a new result.
REQ-006 Byte0_o  out  DataWidth  temperature LSB.
REQ-007 Byte1_o  out  DataWidth  temperature MSB.
REQ-008 SensorCS_n_o  out  1  ADT7310 chip select, active low.
REQ-009 SPI_Data_o  out  DataWidth  byte pushed to SPI master TX FIFO.
REQ-010 SPI_Write_o  out  1  push SPI_Data_o into TX FIFO this cycle.
REQ-011 SPI_ReadNext_o  out  1  pop RX FIFO head this cycle.
REQ-012 SPI_Data_i  in  DataWidth  RX FIFO head, first-word-fall-through.
REQ-013 SPI_FIFOFull_i  in  1  TX FIFO full.
REQ-014 SPI_FIFOEmpty_i  in  1  RX FIFO empty.
REQ-015 SPI_Transmission_i  in  1  SPI master shifting.
REQ-016 ParamCounterPreset_i  in  2*DataWidth  conversion wait preset, cycles.

Function
REQ-017 States: stIdle, stCfgCmd, stCfgVal, stCfgWait, stConvWait, stRdCmd, stRdDummy1, stRdDummy2, stRdWait, stPop0, stPop1, stPop2, stDone.
REQ-018 stIdle: Start_i=1 -> CS_n low, go stCfgCmd; Start_i ignored in all other states.
REQ-019 stCfgCmd/stCfgVal/stRdCmd/stRdDummy1/stRdDummy2: if SPI_FIFOFull_i=0, push 0x08/0x20/0x50/0xFF/0xFF respectively and advance; if full, no push, hold state.
REQ-020 stCfgWait, stRdWait: exit only when SPI_Transmission_i=0 and SPI_FIFOEmpty_i=0; on exit CS_n high (registered, effective next cycle).
REQ-021 stCfgWait exit loads timer with ParamCounterPreset_i, goes stConvWait.
REQ-022 stConvWait: CS_n high; timer decrements each cycle; when timer=0, CS_n low and go stRdCmd; preset N gives N+1 cycles in stConvWait.
REQ-023 SPI_ReadNext_o = !SPI_FIFOEmpty_i in stIdle and stConvWait (flush stale RX bytes); 0 in all write/wait states.
REQ-024 stPop0: pop and discard; stPop1: Byte1_o <= SPI_Data_i, pop; stPop2: Byte0_o <= SPI_Data_i, pop; if RX FIFO empty in any pop state, hold without popping.
REQ-025 stDone: Done_o=1 for exactly one cycle, go stIdle; Byte0_o/Byte1_o hold until next capture.
REQ-026 Start_i=1 in the stDone cycle is ignored; Start_i sampled in the following stIdle cycle begins a new measurement.
REQ-027 Total SPI bytes per measurement exactly 5 (2 config, 3 read); CS_n rises between config and read frames.

Reset
REQ-028 Reset_n_i low, at any time including mid-transfer: state stIdle, timer 0, SensorCS_n_o=1, Done_o=0, SPI_Write_o=0, SPI_ReadNext_o=0, Byte0_o=Byte1_o=0, SPI_Data_o=0.
REQ-029 Reset release: first Start_i is honoured on the first rising edge after Reset_n_i high.

Configuration
REQ-030 Macro MEASURE_FSM_TIMEOUT_EN defined: extra output Error_o (1 bit, reset 0); 8-bit watchdog cleared on entry to stCfgWait/stRdWait, increments each cycle there; at count 255 without exit: CS_n high, Error_o one-cycle pulse, Done_o stays 0, Byte outputs unchanged, go stIdle.
REQ-031 Macro undefined: no Error_o port, no watchdog; stCfgWait/stRdWait wait indefinitely.

Verification
REQ-032 Nominal: preset 0x0003, Start pulse, SPI model returns 0x00,0x12,0x34 -> pushes 08,20,50,FF,FF; 4 cycles in stConvWait; Byte1_o=0x12, Byte0_o=0x34, single Done_o pulse.
REQ-033 Backpressure: SPI_FIFOFull_i=1 for 5 cycles during stCfgVal -> no push during stall, 0x20 pushed once afterwards, sequence completes.
REQ-034 Preset 0x0000 -> exactly 1 cycle in stConvWait; preset 0xFFFF -> 65536 cycles, CS_n high throughout.
REQ-035 Reset asserted in stRdDummy1 -> next cycle CS_n=1, Write=0, Done never pulses; new Start after release gives full 5-byte sequence.
REQ-036 Start_i held high continuously -> back-to-back measurements, one Done_o per measurement, Start ignored while busy.
REQ-037 With MEASURE_FSM_TIMEOUT_EN: SPI_Transmission_i stuck high in stRdWait -> Error_o pulse after 255 cycles, CS_n=1, Byte outputs unchanged.
